// File: rtl/fwd_pkg.sv
// Shared types for the operand forwarding select generator: select codes,
// per-stage tracking record, stall FSM states and the producer test.
package fwd_pkg;

  localparam int unsigned FWD_RD_W = 8;

  typedef enum logic [2:0] {
    SEL_RF  = 3'd0,
    SEL_MEM = 3'd1,
    SEL_WB  = 3'd2,
    SEL_PWB = 3'd3,
    SEL_IMM = 3'd4
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } fwd_stage_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fwd_state_e;

  // x0 is hardwired to zero, so it never has a producer.
  function automatic logic fwd_is_producer(input fwd_stage_t s,
                                           input logic [FWD_RD_W-1:0] rs);
    return s.valid && s.regwrite && (s.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline tracking stage: {valid, rd, regwrite, memread}, async reset.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  fwd_stage_t i_d,
  output fwd_stage_t o_q
);

  fwd_stage_t r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/forward_sel_gen.sv
// Operand forwarding select generator with load-use stall FSM.
// Define FWD_POSTWB_EN to add the post-WB stage and select 3.
module forward_sel_gen
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_use_imm,
  input  logic              flush,
  output logic [SEL_W-1:0]  ex_sel_a,
  output logic [SEL_W-1:0]  ex_sel_b,
  output logic              stall
);

  fwd_stage_t          w_id_stage;
  fwd_stage_t          w_ex;
  fwd_stage_t          w_mem;
  fwd_stage_t          w_wb;
  fwd_state_e          r_state;
  fwd_state_e          w_state_next;
  fwd_sel_e            w_sel_a;
  fwd_sel_e            w_sel_b;
  logic                w_advance;
  logic                w_load_hazard;
  logic [FWD_RD_W-1:0] w_rs1;
  logic [FWD_RD_W-1:0] w_rs2;
  logic                w_unused;

  assign w_rs1 = FWD_RD_W'(id_rs1);
  assign w_rs2 = FWD_RD_W'(id_rs2);

  fwd_stage_reg u_ex  (.clk(clk), .reset(reset), .i_d(w_id_stage), .o_q(w_ex));
  fwd_stage_reg u_mem (.clk(clk), .reset(reset), .i_d(w_ex),       .o_q(w_mem));
  fwd_stage_reg u_wb  (.clk(clk), .reset(reset), .i_d(w_mem),      .o_q(w_wb));

`ifdef FWD_POSTWB_EN
  fwd_stage_t w_pwb;
  fwd_stage_reg u_pwb (.clk(clk), .reset(reset), .i_d(w_wb), .o_q(w_pwb));
  assign w_unused = ^{w_mem.memread, w_wb.memread, w_pwb};
`else
  assign w_unused = ^{w_mem.memread, w_wb};
`endif

  // A load in EX cannot forward in time; only sources the ID instruction uses count.
  assign w_load_hazard = id_valid && w_ex.memread &&
                         (fwd_is_producer(w_ex, w_rs1) ||
                          (!id_use_imm && fwd_is_producer(w_ex, w_rs2)));

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_next = ST_RUN;
        end else if (w_load_hazard) begin
          stall        = 1'b1;
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  assign w_advance = id_valid && !stall && !flush;

  always_comb begin
    w_id_stage = '0;
    if (w_advance) begin
      w_id_stage.valid    = 1'b1;
      w_id_stage.rd       = FWD_RD_W'(id_rd);
      w_id_stage.regwrite = id_regwrite;
      w_id_stage.memread  = id_memread;
    end
  end

  // Later assignments win, so the youngest producer takes priority.
  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
`ifdef FWD_POSTWB_EN
    if (fwd_is_producer(w_wb, w_rs1)) w_sel_a = SEL_PWB;
    if (fwd_is_producer(w_wb, w_rs2)) w_sel_b = SEL_PWB;
`endif
    if (fwd_is_producer(w_mem, w_rs1)) w_sel_a = SEL_WB;
    if (fwd_is_producer(w_mem, w_rs2)) w_sel_b = SEL_WB;
    if (fwd_is_producer(w_ex, w_rs1))  w_sel_a = SEL_MEM;
    if (fwd_is_producer(w_ex, w_rs2))  w_sel_b = SEL_MEM;
    if (id_use_imm)                    w_sel_b = SEL_IMM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      ex_sel_a <= '0;
      ex_sel_b <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_advance) begin
        ex_sel_a <= SEL_W'(w_sel_a);
        ex_sel_b <= SEL_W'(w_sel_b);
      end else begin
        ex_sel_a <= '0;
        ex_sel_b <= '0;
      end
    end
  end

endmodule
